// File: rtl/mul_pkg.sv
// Shared types and widths for the time-shared multiplier front end.
package mul_pkg;

    localparam int unsigned MUL_DW = 8;
    localparam int unsigned MUL_PW = 16;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [MUL_DW-1:0] a;
        logic [MUL_DW-1:0] b;
    } mul_op_t;

endpackage

// File: rtl/DaddaMUL.sv
// Combinational unsigned 8x8 multiplier shared by the arbiter front end.
module DaddaMUL (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] Result
);

    assign Result = 16'(A) * 16'(B);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; search starts one past the last winner.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    int unsigned idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last) + k) % NREQ;
            // Only the first requester found in rotated order may win.
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!any && (i == idx) && req[i]) begin
                    any    = 1'b1;
                    gnt[i] = 1'b1;
                    gnt_id = IDW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Time-shares one combinational 8x8 multiplier between NREQ valid/ready
// requesters; one tagged 16-bit response channel with a handshake counter.
module mul_share_arbiter
    import mul_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*MUL_DW-1:0]   req_a,
    input  logic [NREQ*MUL_DW-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [MUL_PW-1:0]        rsp_result,
    output logic [CNT_W-1:0]         ops_done
);

    state_e             state_q, state_d;
    logic [IDW-1:0]     last_q;
    logic [IDW-1:0]     id_q;
    mul_op_t            op_q;
    logic               rsp_valid_q;
    logic [IDW-1:0]     rsp_id_q;
    logic [MUL_PW-1:0]  rsp_result_q;
    logic [CNT_W-1:0]   ops_q;

    logic [NREQ-1:0]    gnt;
    logic [IDW-1:0]     gnt_id;
    logic               any;
    logic               accept;
    logic               req_hs;
    logic               rsp_hs;
    mul_op_t            op_sel;
    logic [MUL_PW-1:0]  prod;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (req_valid),
        .last   (last_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    DaddaMUL u_mul (
        .A      (op_q.a),
        .B      (op_q.b),
        .Result (prod)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (req_hs) state_d = ST_CALC;
            ST_CALC: state_d = ST_HOLD;
            ST_HOLD: if (rsp_hs) state_d = req_hs ? ST_CALC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake decode; a new request may ride on the response handshake.
    always_comb begin
        accept = 1'b0;
        unique case (state_q)
            ST_IDLE: accept = 1'b1;
            ST_HOLD: accept = rsp_ready;
            default: accept = 1'b0;
        endcase
        req_hs = accept & any;
        rsp_hs = (state_q == ST_HOLD) & rsp_ready;
    end

    // One-hot operand mux from the granted requester.
    always_comb begin
        op_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                op_sel.a = req_a[i*MUL_DW +: MUL_DW];
                op_sel.b = req_b[i*MUL_DW +: MUL_DW];
            end
        end
    end

    assign req_ready = gnt & {NREQ{accept}};

    // Operand capture, response register and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= '0;
            id_q         <= '0;
            last_q       <= IDW'(NREQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            ops_q        <= '0;
        end else begin
            if (req_hs) begin
                op_q   <= op_sel;
                id_q   <= gnt_id;
                last_q <= gnt_id;
            end
            if (state_q == ST_CALC) begin
                rsp_valid_q  <= 1'b1;
                rsp_result_q <= prod;
                rsp_id_q     <= id_q;
            end else if (rsp_hs) begin
                rsp_valid_q <= 1'b0;
                ops_q       <= ops_q + 16'd1;
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign ops_done   = ops_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed scenarios plus a randomized soak
// against a transaction-level round-robin/multiply model.
module tb_mul_share_arbiter;

    localparam int NREQ = 3;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*8-1:0]   req_a;
    logic [NREQ*8-1:0]   req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [15:0]         rsp_result;
    logic [15:0]         ops_done;

    int checks;
    int errors;
    int ops_exp;

    mul_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .ops_done   (ops_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Round-robin rule: first valid requester after the last winner.
    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        next_cycle();
        rst_n = 1'b1;
        ops_exp = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        checks++; if (rsp_result !== 16'd0) begin errors++; $display("FAIL reset_rsp_result: got %0d want 0", rsp_result); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops_done: got %0d want 0", ops_done); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready: got %b want 000", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        ops_exp = 0;
    endtask

    task automatic test_single();
        req_a = '0; req_b = '0;
        req_a[7:0] = 8'd3; req_b[7:0] = 8'd5;
        req_valid = 3'b001; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready: got %b want 001", req_ready); end
        next_cycle();
        req_valid = '0;
        req_a[7:0] = 8'hAA;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_calc_valid: got %0b want 0", rsp_valid); end
        next_cycle();
        #1;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %0b want 1", rsp_valid); end
        checks++; if (rsp_result !== 16'd15) begin errors++; $display("FAIL single_result: got %0d want 15", rsp_result); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", rsp_id); end
        next_cycle();
        ops_exp++;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_clear: got %0b want 0", rsp_valid); end
        checks++; if (ops_done !== 16'(ops_exp)) begin errors++; $display("FAIL single_ops: got %0d want %0d", ops_done, ops_exp); end
        checks++; if (rsp_result !== 16'd15) begin errors++; $display("FAIL single_result_hold: got %0d want 15", rsp_result); end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] want;
        @(negedge clk);
        do_reset();
        req_a = '0; req_b = '0;
        req_a[7:0] = 8'd10; req_b[7:0] = 8'd20;
        req_a[15:8] = 8'd7; req_b[15:8] = 8'd9;
        req_valid = 3'b011; rsp_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            want = (n % 2 == 0) ? 3'b001 : 3'b010;
            checks++; if (req_ready !== want) begin errors++; $display("FAIL cont_grant%0d: got %b want %b", n, req_ready, want); end
            if (n > 0) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((n - 1) % 2) || rsp_result !== (((n - 1) % 2 == 0) ? 16'd200 : 16'd63)) begin
                    errors++; $display("FAIL cont_rsp%0d: got v=%0b id=%0d res=%0d", n, rsp_valid, rsp_id, rsp_result);
                end
            end
            next_cycle();
            #1;
            checks++; if (req_ready !== 3'b000 || rsp_valid !== 1'b0) begin errors++; $display("FAIL cont_calc%0d: got ready=%b v=%0b want 000/0", n, req_ready, rsp_valid); end
            next_cycle();
        end
        req_valid = '0;
        #1;
        checks++; if (rsp_id !== 2'd1 || rsp_result !== 16'd63) begin errors++; $display("FAIL cont_last: got id=%0d res=%0d want 1/63", rsp_id, rsp_result); end
        next_cycle();
        ops_exp = 6;
        #1;
        checks++; if (ops_done !== 16'(ops_exp)) begin errors++; $display("FAIL cont_ops: got %0d want %0d", ops_done, ops_exp); end
    endtask

    task automatic test_backpressure();
        req_a[7:0] = 8'd255; req_b[7:0] = 8'd255;
        req_valid = 3'b001; rsp_ready = 1'b0;
        next_cycle();
        req_valid = 3'b010;
        req_a[15:8] = 8'd2; req_b[15:8] = 8'd3;
        #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL bp_calc_ready: got %b want 000", req_ready); end
        next_cycle();
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 16'd65025 || rsp_id !== 2'd0 || req_ready !== 3'b000) begin
                errors++; $display("FAIL bp_hold%0d: got v=%0b res=%0d id=%0d ready=%b", n, rsp_valid, rsp_result, rsp_id, req_ready);
            end
            next_cycle();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL bp_release_ready: got %b want 010", req_ready); end
        next_cycle();
        req_valid = '0;
        ops_exp++;
        #1;
        checks++; if (rsp_valid !== 1'b0 || ops_done !== 16'(ops_exp)) begin errors++; $display("FAIL bp_after: got v=%0b ops=%0d want 0/%0d", rsp_valid, ops_done, ops_exp); end
        next_cycle();
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 16'd6 || rsp_id !== 2'd1) begin errors++; $display("FAIL bp_second: got v=%0b res=%0d id=%0d want 1/6/1", rsp_valid, rsp_result, rsp_id); end
        next_cycle();
        ops_exp++;
    endtask

    task automatic test_reset_mid_calc();
        req_a[7:0] = 8'd9; req_b[7:0] = 8'd9;
        req_valid = 3'b001; rsp_ready = 1'b1;
        next_cycle();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_result !== 16'd0 || rsp_id !== 2'd0 || ops_done !== 16'd0) begin
            errors++; $display("FAIL midrst_async: got v=%0b res=%0d id=%0d ops=%0d", rsp_valid, rsp_result, rsp_id, ops_done);
        end
        next_cycle();
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp: got %0b want 0", rsp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        ops_exp = 0;
        req_a[7:0] = 8'd4; req_b[7:0] = 8'd6;
        req_a[15:8] = 8'd1; req_b[15:8] = 8'd1;
        req_valid = 3'b011;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL midrst_grant: got %b want 001", req_ready); end
        next_cycle();
        req_valid = '0;
        next_cycle();
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 16'd24 || rsp_id !== 2'd0) begin errors++; $display("FAIL midrst_rsp: got v=%0b res=%0d id=%0d want 1/24/0", rsp_valid, rsp_result, rsp_id); end
        next_cycle();
        ops_exp++;
    endtask

    task automatic test_random_soak();
        logic [7:0]      pa [NREQ];
        logic [7:0]      pb [NREQ];
        bit              pend [NREQ];
        int              waitc [NREQ];
        int              m_last, g, accepted, completed;
        bit              m_calc, m_hold, acc, done, idle_req;
        logic [IDW-1:0]  m_id, c_id;
        logic [15:0]     m_res, c_res, m_ops;
        logic [NREQ-1:0] exp_ready;

        @(negedge clk);
        do_reset();
        for (int i = 0; i < NREQ; i++) begin pa[i] = '0; pb[i] = '0; pend[i] = 1'b0; waitc[i] = 0; end
        m_last = NREQ - 1; m_calc = 1'b0; m_hold = 1'b0; m_ops = '0;
        m_id = '0; c_id = '0; m_res = '0; c_res = '0;
        accepted = 0; completed = 0; done = 1'b0;

        for (int c = 0; c < 20000 && !done; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && accepted < 1000 && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pa[i] = 8'($urandom);
                    pb[i] = 8'($urandom);
                end
                req_valid[i] = pend[i];
                req_a[i*8 +: 8] = pend[i] ? pa[i] : 8'($urandom);
                req_b[i*8 +: 8] = pend[i] ? pb[i] : 8'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = (!m_calc && !m_hold) || (m_hold && rsp_ready);
            g = pick(req_valid, m_last);
            exp_ready = '0;
            if (acc && g >= 0) exp_ready[g] = 1'b1;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL soak_ready c=%0d: got %b want %b", c, req_ready, exp_ready); end
            checks++; if (rsp_valid !== m_hold) begin errors++; $display("FAIL soak_valid c=%0d: got %0b want %0b", c, rsp_valid, m_hold); end
            if (m_hold) begin
                checks++;
                if (rsp_id !== m_id || rsp_result !== m_res) begin
                    errors++; $display("FAIL soak_rsp c=%0d: got id=%0d res=%0d want id=%0d res=%0d", c, rsp_id, rsp_result, m_id, m_res);
                end
            end
            checks++; if (ops_done !== m_ops) begin errors++; $display("FAIL soak_ops c=%0d: got %0d want %0d", c, ops_done, m_ops); end

            if (m_hold && rsp_ready) begin
                m_hold = 1'b0; m_ops = m_ops + 16'd1; completed++;
            end
            if (m_calc) begin
                m_hold = 1'b1; m_id = c_id; m_res = c_res;
            end
            m_calc = 1'b0;
            if (acc && g >= 0) begin
                m_calc = 1'b1; c_id = IDW'(g);
                c_res = 16'(pa[g]) * 16'(pb[g]);
                m_last = g; pend[g] = 1'b0; waitc[g] = 0; accepted++;
                for (int i = 0; i < NREQ; i++) begin
                    if (pend[i]) begin
                        waitc[i]++;
                        checks++; if (waitc[i] > NREQ - 1) begin errors++; $display("FAIL soak_fair req%0d: waited %0d grants, limit %0d", i, waitc[i], NREQ - 1); end
                    end
                end
            end
            idle_req = 1'b1;
            for (int i = 0; i < NREQ; i++) if (pend[i]) idle_req = 1'b0;
            done = (accepted >= 1000) && !m_calc && !m_hold && idle_req;
            next_cycle();
        end
        req_valid = '0;
        checks++; if (!done) begin errors++; $display("FAIL soak_timeout: accepted %0d completed %0d", accepted, completed); end
        checks++; if (completed != accepted) begin errors++; $display("FAIL soak_count: completed %0d want %0d", completed, accepted); end
        #1;
        checks++; if (ops_done !== m_ops) begin errors++; $display("FAIL soak_final_ops: got %0d want %0d", ops_done, m_ops); end
        ops_exp = int'(m_ops);
    endtask

    task automatic test_counter_wrap();
        logic [15:0] want;
        @(negedge clk);
        req_valid = '0; rsp_ready = 1'b1;
        force dut.ops_q = 16'hFFFE;
        #1;
        release dut.ops_q;
        want = 16'hFFFE;
        for (int n = 0; n < 2; n++) begin
            req_a[7:0] = 8'd1; req_b[7:0] = 8'd1;
            req_valid = 3'b001;
            next_cycle();
            req_valid = '0;
            next_cycle();
            next_cycle();
            want = want + 16'd1;
            #1;
            checks++; if (ops_done !== want) begin errors++; $display("FAIL wrap%0d: got %h want %h", n, ops_done, want); end
        end
    endtask

    initial begin
        checks = 0; errors = 0; ops_exp = 0;
        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid_calc();
        test_random_soak();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
